// File: rtl/adder_pkg.sv
// Shared definitions for the segmented pipelined add/subtract unit.
package adder_pkg;

  localparam int unsigned DefWidth = 10;
  localparam int unsigned DefSegW  = 5;

  // Per-beat operation mode, carried on in_sub.
  typedef enum logic {
    OpAdd = 1'b0,
    OpSub = 1'b1
  } op_e;

  // Status flags of one result beat.
  typedef struct packed {
    logic carry;
    logic ovf;
  } flags_t;

  // Number of pipeline stages: ceil(width / seg_w).
  function automatic int unsigned nstg(int unsigned width, int unsigned seg_w);
    return (width + seg_w - 1) / seg_w;
  endfunction

  // Lowest result bit resolved by stage k.
  function automatic int unsigned seg_lo(int unsigned seg_w, int unsigned k);
    return k * seg_w;
  endfunction

  // Bits resolved by stage k; only the last segment may be narrower.
  function automatic int unsigned seg_width(int unsigned width, int unsigned seg_w,
                                            int unsigned k);
    return (k == nstg(width, seg_w) - 1) ? width - k * seg_w : seg_w;
  endfunction

endpackage

// File: rtl/seg_adder_pipe_if.sv
// Operand/result stream bundle of the segmented adder.
interface seg_adder_pipe_if
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
);

  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, in_sub, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf
  );

  // The adder itself.
  modport slave (
    input  in_valid, in_sub, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf
  );

endinterface

// File: rtl/adder_seg_stage.sv
// One pipeline stage: resolves SW result bits starting at bit LO and forwards the
// operands, partial sum and carry to the next stage.
module adder_seg_stage
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned LO    = 0,
  parameter int unsigned SW    = DefSegW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ready,     // stage is empty or its beat leaves this cycle
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_sum,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,      // already conditionally inverted
  input  logic             up_carry,
  output logic             valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             carry
);

  logic             valid_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [SW:0]      seg;

  // Segment adder; splice its bits into the partial sum.
  always_comb begin
    seg   = {1'b0, up_a[LO+:SW]} + {1'b0, up_b[LO+:SW]} + {{SW{1'b0}}, up_carry};
    sum_d = up_sum;
    sum_d[LO+:SW] = seg[SW-1:0];
  end

  // Stage register; data only moves with a valid beat so held results stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
    end else if (ready) begin
      valid_q <= up_valid;
      if (up_valid) begin
        sum_q   <= sum_d;
        a_q     <= up_a;
        b_q     <= up_b;
        carry_q <= seg[SW];
      end
    end
  end

  assign valid = valid_q;
  assign sum   = sum_q;
  assign a     = a_q;
  assign b     = b_q;
  assign carry = carry_q;

endmodule

// File: rtl/seg_adder_pipe.sv
// Pipelined two's-complement add/subtract unit, one SEG_W-bit carry segment per stage,
// valid/ready streaming on both sides.
module seg_adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SEG_W = DefSegW
) (
  input logic            clk,
  input logic            rst_n,
  seg_adder_pipe_if.slave bus
);

  localparam int unsigned NSTG = nstg(WIDTH, SEG_W);

  // Index k is the input of stage k; index NSTG is the output of the last stage.
  logic [NSTG:0]    vld_w;
  logic [WIDTH-1:0] sum_w   [NSTG+1];
  logic [WIDTH-1:0] a_w     [NSTG+1];
  logic [WIDTH-1:0] b_w     [NSTG+1];
  logic             carry_w [NSTG+1];
  logic [NSTG-1:0]  stg_ready;
  logic             is_sub;
  flags_t           flags;

  // Subtraction is A + ~B + 1: invert B and seed the carry.
  assign is_sub     = (op_e'(bus.in_sub) == OpSub);
  assign vld_w[0]   = bus.in_valid;
  assign sum_w[0]   = '0;
  assign a_w[0]     = bus.in_a;
  assign b_w[0]     = is_sub ? ~bus.in_b : bus.in_b;
  assign carry_w[0] = is_sub;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    localparam int unsigned Lo = seg_lo(SEG_W, k);
    localparam int unsigned Sw = seg_width(WIDTH, SEG_W, k);

    // Flattened form of ready_k = !valid_k || ready_{k+1}: stage k can load unless
    // every stage from k to the end is occupied and the sink is stalled.
    assign stg_ready[k] = bus.out_ready || !(&vld_w[NSTG:k+1]);

    adder_seg_stage #(
      .WIDTH (WIDTH),
      .LO    (Lo),
      .SW    (Sw)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .ready    (stg_ready[k]),
      .up_valid (vld_w[k]),
      .up_sum   (sum_w[k]),
      .up_a     (a_w[k]),
      .up_b     (b_w[k]),
      .up_carry (carry_w[k]),
      .valid    (vld_w[k+1]),
      .sum      (sum_w[k+1]),
      .a        (a_w[k+1]),
      .b        (b_w[k+1]),
      .carry    (carry_w[k+1])
    );
  end

  // Overflow: operands of equal sign yielding a result of the other sign.
  assign flags.carry = carry_w[NSTG];
  assign flags.ovf   = (a_w[NSTG][WIDTH-1] == b_w[NSTG][WIDTH-1]) &&
                       (sum_w[NSTG][WIDTH-1] != a_w[NSTG][WIDTH-1]);

  assign bus.in_ready  = stg_ready[0];
  assign bus.out_valid = vld_w[NSTG];
  assign bus.out_sum   = sum_w[NSTG];
  assign bus.out_carry = flags.carry;
  assign bus.out_ovf   = flags.ovf;

  // Only the sign bits of the operands matter once every segment is resolved.
  logic unused_low_ops;
  assign unused_low_ops = ^{a_w[NSTG][WIDTH-2:0], b_w[NSTG][WIDTH-2:0]};

endmodule

// File: tb/tb_seg_adder_pipe.sv
// Bench for seg_adder_pipe: three configurations (10/5, 16/16, 17/4) against an
// arithmetic reference model with an in-order scoreboard.
module tb_seg_adder_pipe;

  typedef struct {
    logic [16:0] sum;
    bit          carry;
    bit          ovf;
    longint      acc;
    bit          seen;
  } exp_t;

  logic clk;
  logic rst_n;

  // Stimulus state, written only by the stimulus process.
  logic        vld, sub, en_o, ordy10;
  logic [16:0] a_drv, b_drv;
  bit          rst_chk, post_rel, stall_chk, lat_en, end_chk;
  int          n_timeout;

  // Checker state, written only by the compare process.
  int     total, bad, seen_to;
  longint cyc;
  exp_t   q [3][$];

  seg_adder_pipe_if #(.WIDTH(10)) if10 ();
  seg_adder_pipe_if #(.WIDTH(16)) if16 ();
  seg_adder_pipe_if #(.WIDTH(17)) if17 ();

  assign if10.in_valid  = vld;
  assign if10.in_sub    = sub;
  assign if10.in_a      = a_drv[9:0];
  assign if10.in_b      = b_drv[9:0];
  assign if10.out_ready = ordy10;
  assign if16.in_valid  = vld & en_o;
  assign if16.in_sub    = sub;
  assign if16.in_a      = a_drv[15:0];
  assign if16.in_b      = b_drv[15:0];
  assign if16.out_ready = 1'b1;
  assign if17.in_valid  = vld & en_o;
  assign if17.in_sub    = sub;
  assign if17.in_a      = a_drv;
  assign if17.in_b      = b_drv;
  assign if17.out_ready = 1'b1;

  seg_adder_pipe #(.WIDTH(10), .SEG_W(5))  dut10 (.clk(clk), .rst_n(rst_n), .bus(if10));
  seg_adder_pipe #(.WIDTH(16), .SEG_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  seg_adder_pipe #(.WIDTH(17), .SEG_W(4))  dut17 (.clk(clk), .rst_n(rst_n), .bus(if17));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic modulo 2^w, signed range test for overflow.
  function automatic exp_t model(input int w, input bit s, input logic [16:0] a,
                                 input logic [16:0] b);
    exp_t   e;
    longint m, av, bv, sa, sb, r, u;
    m  = longint'(1) << w;
    av = longint'(a) & (m - 1);
    bv = longint'(b) & (m - 1);
    sa = (av >= m / 2) ? av - m : av;
    sb = (bv >= m / 2) ? bv - m : bv;
    if (!s) begin
      u       = av + bv;
      e.carry = (u >= m);
      r       = sa + sb;
    end else begin
      u       = av + m - bv;
      e.carry = (av >= bv);
      r       = sa - sb;
    end
    e.sum  = 17'(u % m);
    e.ovf  = (r < -(m / 2)) || (r > m / 2 - 1);
    e.acc  = 0;
    e.seen = 1'b0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [16:0] got, input logic [16:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  // One DUT per call: compare the displayed beat with the scoreboard head, then
  // retire/enqueue according to the handshakes that complete at the coming edge.
  task automatic scan(input int id, input int w, input int ns, input bit ov,
                      input logic [16:0] os, input bit oc, input bit oo, input bit ordy,
                      input bit iv, input bit ir, input bit isub,
                      input logic [16:0] ia, input logic [16:0] ib);
    exp_t e;
    if (ov) begin
      if (q[id].size() == 0) begin
        chk($sformatf("w%0d_unexpected_beat", w), 17'(ov), 17'd0);
      end else begin
        e = q[id][0];
        chk($sformatf("w%0d_sum", w), os, e.sum);
        chk($sformatf("w%0d_carry", w), 17'(oc), 17'(e.carry));
        chk($sformatf("w%0d_ovf", w), 17'(oo), 17'(e.ovf));
        if (!e.seen) begin
          if (lat_en) chk($sformatf("w%0d_latency", w), 17'(cyc - e.acc), 17'(ns));
          q[id][0].seen = 1'b1;
        end
        if (ordy) void'(q[id].pop_front());
      end
    end
    if (iv && ir) begin
      e     = model(w, isub, ia, ib);
      e.acc = cyc;
      q[id].push_back(e);
    end
  endtask

  // Compare process: all comparisons happen here, on the falling edge.
  initial begin
    exp_t p;
    total = 0; bad = 0; seen_to = 0; cyc = 0;
    p = model(10, 1'b0, 17'd1023, 17'd1);
    chk("pin_1023p1_sum", p.sum, 17'd0);
    chk("pin_1023p1_carry", 17'(p.carry), 17'd1);
    p = model(10, 1'b1, 17'd5, 17'd7);
    chk("pin_5m7_sum", p.sum, 17'd1022);
    chk("pin_5m7_carry", 17'(p.carry), 17'd0);
    p = model(10, 1'b0, 17'd511, 17'd1);
    chk("pin_511p1_ovf", 17'(p.ovf), 17'd1);
    p = model(10, 1'b1, 17'd512, 17'd1);
    chk("pin_512m1_sum", p.sum, 17'd511);
    chk("pin_512m1_ovf", 17'(p.ovf), 17'd1);
    forever begin
      @(negedge clk);
      if (n_timeout != seen_to) begin
        chk("handshake_timeout", 17'(n_timeout), 17'(seen_to));
        seen_to = n_timeout;
      end
      if (!rst_n) begin
        for (int i = 0; i < 3; i++) q[i].delete();
        if (rst_chk) begin
          chk("rst_w10_out_valid", 17'(if10.out_valid), 17'd0);
          chk("rst_w10_out_sum", 17'(if10.out_sum), 17'd0);
          chk("rst_w10_out_carry", 17'(if10.out_carry), 17'd0);
          chk("rst_w10_out_ovf", 17'(if10.out_ovf), 17'd0);
          chk("rst_w16_out_valid", 17'(if16.out_valid), 17'd0);
          chk("rst_w17_out_valid", 17'(if17.out_valid), 17'd0);
        end
      end else begin
        if (post_rel) begin
          chk("rel_w10_in_ready", 17'(if10.in_ready), 17'd1);
          chk("rel_w16_in_ready", 17'(if16.in_ready), 17'd1);
          chk("rel_w17_in_ready", 17'(if17.in_ready), 17'd1);
        end
        if (stall_chk) begin
          chk("stall_w10_in_ready", 17'(if10.in_ready), 17'd0);
          chk("stall_w10_out_valid", 17'(if10.out_valid), 17'd1);
        end
        scan(0, 10, 2, if10.out_valid, {7'd0, if10.out_sum}, if10.out_carry, if10.out_ovf,
             if10.out_ready, if10.in_valid, if10.in_ready, if10.in_sub,
             {7'd0, if10.in_a}, {7'd0, if10.in_b});
        scan(1, 16, 1, if16.out_valid, {1'b0, if16.out_sum}, if16.out_carry, if16.out_ovf,
             if16.out_ready, if16.in_valid, if16.in_ready, if16.in_sub,
             {1'b0, if16.in_a}, {1'b0, if16.in_b});
        scan(2, 17, 5, if17.out_valid, if17.out_sum, if17.out_carry, if17.out_ovf,
             if17.out_ready, if17.in_valid, if17.in_ready, if17.in_sub,
             if17.in_a, if17.in_b);
        if (end_chk) begin
          chk("drain_w10", 17'(q[0].size()), 17'd0);
          chk("drain_w16", 17'(q[1].size()), 17'd0);
          chk("drain_w17", 17'(q[2].size()), 17'd0);
        end
      end
      cyc++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input bit s, input logic [16:0] a, input logic [16:0] b);
    int n;
    bit rdy;
    sub = s; a_drv = a; b_drv = b; vld = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = if10.in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 100);
    if (!rdy) n_timeout++;
    #1 vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_chk = 1'b1;
    rst_n   = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    rst_chk  = 1'b0;
    post_rel = 1'b1;
    @(negedge clk);
    #1 post_rel = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [16:0] dir_a [12] = '{17'd1023, 17'd5, 17'd7, 17'd511, 17'd512, 17'd0, 17'd0,
                              17'd1023, 17'd0, 17'h1FFFF, 17'h0FFFF, 17'h10000};
  logic [16:0] dir_b [12] = '{17'd1, 17'd7, 17'd5, 17'd1, 17'd1, 17'd0, 17'd0,
                              17'd1023, 17'd1023, 17'd1, 17'd1, 17'd1};
  bit          dir_s [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                              1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  // Stimulus process.
  initial begin
    bit done_r;
    vld = 1'b0; sub = 1'b0; a_drv = '0; b_drv = '0; en_o = 1'b1; ordy10 = 1'b1;
    rst_chk = 1'b1; post_rel = 1'b0; stall_chk = 1'b0; lat_en = 1'b1; end_chk = 1'b0;
    n_timeout = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rst_chk  = 1'b0;
    post_rel = 1'b1;
    @(negedge clk);
    #1 post_rel = 1'b0;
    @(posedge clk);
    #1;

    // Directed corner vectors, all three configurations.
    for (int i = 0; i < 12; i++) send(dir_s[i], dir_a[i], dir_b[i]);
    idle(8);

    // Full-rate stream with alternating mode.
    for (int i = 0; i < 300; i++) send(i[0], 17'($urandom), 17'($urandom));
    idle(8);

    // Backpressure: two beats fill the 10-bit pipe, a third waits.
    en_o = 1'b0; lat_en = 1'b0; ordy10 = 1'b0;
    send(1'b0, 17'd100, 17'd23);
    send(1'b1, 17'd3, 17'd900);
    sub = 1'b0; a_drv = 17'd600; b_drv = 17'd600; vld = 1'b1;
    stall_chk = 1'b1;
    repeat (5) @(posedge clk);
    #1 stall_chk = 1'b0;
    ordy10 = 1'b1;
    send(1'b0, 17'd600, 17'd600);
    idle(6);

    // Random sink stalls against a continuous source.
    done_r = 1'b0;
    fork
      begin
        for (int i = 0; i < 120; i++) send(i[0], 17'($urandom), 17'($urandom));
        done_r = 1'b1;
      end
      begin
        while (!done_r) begin
          @(posedge clk);
          #1 ordy10 = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ordy10 = 1'b1;
    idle(10);
    lat_en = 1'b1; en_o = 1'b1;

    // Reset with beats in flight: nothing stale may emerge afterwards.
    send(1'b0, 17'd1000, 17'd50);
    send(1'b1, 17'd20, 17'd40);
    #1;
    do_reset();
    idle(10);
    send(1'b1, 17'd7, 17'd5);
    idle(10);

    end_chk = 1'b1;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_adder_pipe.md
Name: seg_adder_pipe

Overview:
- Parametrised, pipelined two's-complement add/subtract unit, successor to the team's fixed 10-bit combinational adder.
- Splits the carry chain into SEG_W-bit segments, one register stage per segment, so wide operands close timing.
- Streams operands with valid/ready handshakes on both sides, one result per cycle at full throughput.
- Supports per-transaction add/subtract mode and flags carry and signed overflow.

Parameters:
- WIDTH, 10, operand and result width in bits (>= 2).
- SEG_W, 5, bits resolved per pipeline stage (1..WIDTH).
- NSTG, derived = ceil(WIDTH/SEG_W), number of stages; the last segment may be narrower. Not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_sub  input  1  0 = A+B, 1 = A-B.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  result, modulo 2^WIDTH.
- out_carry  output  1  add: carry out of MSB. Sub: 1 = no borrow (A >= B unsigned).
- out_ovf  output  1  signed overflow.

Behaviour:
- Reset: asynchronous on rst_n low. All stage valids clear; out_valid=0, out_sum=0, out_carry=0, out_ovf=0. in_ready=1 on the first cycle after release.
- Reset mid-operation: every in-flight beat is discarded. Nothing is emitted after release until new input is accepted.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Once asserted, out_valid and all out_* values hold stable until the transfer completes.
  - in_valid has no dependency on in_ready.
- Stage k (0..NSTG-1):
  - Holds a valid bit, result bits [0 .. (k+1)*SEG_W-1] resolved so far, the running carry, and the unresolved upper operand bits (B already conditionally inverted).
  - Stage 0 adds segment 0 of A and B' with cin = in_sub, where B' = in_sub ? ~in_b : in_b.
  - Stage k adds segment k using the carry registered by stage k-1.
- Advance rule: stage k loads when it is empty or its contents move on this cycle.
  - ready_k = !valid_k || ready_{k+1}; ready_NSTG = out_ready.
  - in_ready = ready_0. The in_ready path is combinational through the chain.
  - No bubbles are inserted while the chain flows.
- Latency and throughput:
  - Latency: exactly NSTG cycles from the input transfer edge to out_valid, with no backpressure.
  - Throughput: one beat per cycle while out_ready=1.
  - Full pipeline with out_ready=0: in_ready=0, all stages hold their contents.
- Ordering: results leave in acceptance order. Mode travels with its beat, so mixed add/sub streams are legal.
- Flags, computed in the final stage:
  - out_carry = carry out of bit WIDTH-1.
  - out_ovf = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]). The A and B' sign bits are carried down the pipe.
- Widths:
  - Last segment width = WIDTH - (NSTG-1)*SEG_W.
  - SEG_W >= WIDTH gives NSTG=1, a single registered stage.
  - Wrap-around: the sum is truncated to WIDTH bits; the carry is reported, never saturated.
- Simultaneous events: with the pipeline full, output transfer and input transfer may occur in the same cycle. Both are honoured and occupancy stays constant.
- The unit contains no internal buffering beyond the NSTG stage registers.

Decomposition:
- Shared package adder_pkg:
  - function nstg(width, seg_w) returning the ceiling division.
  - typedef/localparam for the stage record field widths, for reuse by the bench's reference model.
- One natural sub-module: adder_seg_stage.
  - Contents: one segment adder, its valid/ready register, and pass-through of the upper operand bits and sign bits.
  - Instantiated NSTG times by a generate loop, with the segment width for the last stage computed.

Test Plan:
- Defaults (WIDTH=10, SEG_W=5): add, A=1023, B=1 -> exactly 2 cycles later out_sum=0, out_carry=1, out_ovf=0. The carry crosses the segment boundary.
- Sub, A=5, B=7 -> out_sum=1022, out_carry=0, out_ovf=0. Sub, A=7, B=5 -> out_sum=2, out_carry=1.
- Signed overflow: add 511+1 -> out_sum=512, out_ovf=1. Sub 512-1 -> out_sum=511, out_ovf=1.
- Exhaustive stream:
  - Stimulus: all 1024x1024 A/B pairs read from text via $readmemb, mode alternating per beat, out_ready=1.
  - Expected: one result per cycle after a 2-cycle fill, every result matching the reference model, in order.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles with 3 beats offered.
  - Expected: in_ready falls after the 2 stages fill; the held output stays stable. On release, the beats emerge in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately (asynchronous). After release, no stale beat appears. Repeat with WIDTH=16/SEG_W=16 and WIDTH=17/SEG_W=4 (NSTG=5, last segment 1 bit).
